// File: rtl/frank_seq_pkg.sv
// frank_seq_pkg: shared encodings for the FRANK6000 program sequencer
package frank_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_HALT  = 3'd2,
    S_STEP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;
  localparam logic [1:0] J_INC  = 2'd0;
  localparam logic [1:0] J_JUMP = 2'd1;
  localparam logic [1:0] J_RTRN = 2'd2;
  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_OVF  = 2'd1;
  localparam logic [1:0] F_UNF  = 2'd2;
  localparam logic [1:0] F_ILL  = 2'd3;
  function automatic logic [1:0] fault_code(input logic ill, input logic ovf, input logic unf);
    return ill ? F_ILL : ovf ? F_OVF : unf ? F_UNF : F_NONE;
  endfunction
endpackage

// File: rtl/frank_call_stack.sv
// frank_call_stack: LIFO of return addresses with occupancy and full/empty flags
module frank_call_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_top,
  output logic [SP_W-1:0]  o_sp,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [2**AW];
  logic [SP_W-1:0]  r_sp;
  logic [AW-1:0]    w_top_idx;
  assign o_sp      = r_sp;
  assign o_full    = r_sp == SP_W'(DEPTH);
  assign o_empty   = r_sp == '0;
  assign w_top_idx = AW'(r_sp - SP_W'(1));
  assign o_top     = o_empty ? '0 : r_mem[w_top_idx];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sp <= '0;
    else if (i_clear) r_sp <= '0;
    else if (i_push && !o_full) r_sp <= r_sp + SP_W'(1);
    else if (i_pop && !o_empty) r_sp <= r_sp - SP_W'(1);
  always_ff @(posedge i_clk)
    if (i_push && !o_full) r_mem[AW'(r_sp)] <= i_din;
endmodule

// File: rtl/frank_sequencer.sv
// frank_sequencer: PC, next-PC mux, call stack, instruction memory and run-control FSM
module frank_sequencer
  import frank_seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load_valid,
  input  logic [INSTR_W-1:0] i_load_instr,
  output logic               o_load_ready,
  input  logic               i_start,
  input  logic               i_halt_req,
  input  logic               i_step,
  input  logic               i_clear,
  input  logic               i_PCw,
  input  logic [1:0]         i_j_mode,
  input  logic               i_jump_flag,
  input  logic               i_call,
  input  logic               i_rtrn,
  output logic [PC_W-1:0]    o_PC,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_exec_en,
  output logic [2:0]         o_state,
  output logic [SP_W-1:0]    o_sp,
  output logic [1:0]         o_fault
);
  state_t             r_state, w_next;
  logic [PC_W-1:0]    r_pc, r_load_addr, w_pc_inc, w_pc_next, w_top;
  logic [INSTR_W-1:0] r_mem [2**PC_W];
  logic [1:0]         r_fault;
  logic w_ill, w_ovf, w_unf, w_err, w_full, w_empty, w_start, w_clear, w_load;
  assign o_PC     = r_pc;
  assign o_instr  = r_mem[r_pc];
  assign o_fault  = r_fault;
  assign w_start  = r_state == S_IDLE && i_start;
  assign w_clear  = r_state == S_FAULT && i_clear;
  assign w_load   = o_load_ready && i_load_valid;
  assign w_ill    = o_exec_en && ((i_PCw && i_j_mode == 2'd3) || (i_call && i_rtrn));
  assign w_ovf    = o_exec_en && i_call && w_full;
  assign w_unf    = o_exec_en && i_rtrn && w_empty;
  assign w_err    = w_ill || w_ovf || w_unf;
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_next = i_j_mode == J_RTRN ? w_top :
                     (i_j_mode == J_INC || !i_jump_flag) ? w_pc_inc : o_instr[PC_W-1:0];
  frank_call_stack #(.DEPTH(STACK_DEPTH), .WIDTH(PC_W), .SP_W(SP_W)) u_stack (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .i_push  (o_exec_en && i_call && !w_err),
    .i_pop   (o_exec_en && i_rtrn && !w_err),
    .i_din   (w_pc_inc),
    .o_top   (w_top),
    .o_sp    (o_sp),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // A faulting instruction takes priority over a halt request in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_err ? S_FAULT : i_halt_req ? S_HALT : S_RUN;
      S_HALT:  w_next = i_start ? S_RUN : i_step ? S_STEP : S_HALT;
      S_STEP:  w_next = w_err ? S_FAULT : S_HALT;
      S_FAULT: w_next = i_clear ? S_IDLE : S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_exec_en    = r_state == S_RUN || r_state == S_STEP;
    o_load_ready = r_state == S_IDLE;
    o_state      = r_state;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_pc <= '0;
    else if (w_start || w_clear) r_pc <= '0;
    else if (o_exec_en && i_PCw && !w_err) r_pc <= w_pc_next;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_fault <= F_NONE;
    else if (w_clear) r_fault <= F_NONE;
    else if (w_err) r_fault <= fault_code(w_ill, w_ovf, w_unf);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_load_addr <= '0;
    else if (w_start || w_clear) r_load_addr <= '0;
    else if (w_load) r_load_addr <= r_load_addr + PC_W'(1);
  always_ff @(posedge i_clk)
    if (w_load) r_mem[r_load_addr] <= i_load_instr;
endmodule

// File: tb/tb_frank_sequencer.sv
// tb_frank_sequencer: directed and random checks against a queue-based sequencer model
module tb_frank_sequencer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic load_valid, start, halt_req, step, clear, pcw, flag, call, rtrn;
  logic [15:0] load_instr;
  logic [1:0]  jm;
  logic        load_ready, exec_en;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [2:0]  state, sp;
  logic [1:0]  fault;
  int n_chk = 0, n_fail = 0;
  int m_state, m_pc, m_la, m_fault;
  int m_stk[$];
  logic [15:0] m_mem [256];
  bit m_val [256];
  always #5 clk = ~clk;
  frank_sequencer #(.PC_W(8), .INSTR_W(16), .STACK_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid), .i_load_instr(load_instr),
    .o_load_ready(load_ready), .i_start(start), .i_halt_req(halt_req), .i_step(step),
    .i_clear(clear), .i_PCw(pcw), .i_j_mode(jm), .i_jump_flag(flag), .i_call(call),
    .i_rtrn(rtrn), .o_PC(pc), .o_instr(instr), .o_exec_en(exec_en), .o_state(state),
    .o_sp(sp), .o_fault(fault)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    check("state", 32'(state), m_state);
    check("pc", 32'(pc), m_pc);
    check("sp", 32'(sp), m_stk.size());
    check("fault", 32'(fault), m_fault);
    check("exec_en", 32'(exec_en), 32'(m_state == 1 || m_state == 3));
    check("load_ready", 32'(load_ready), 32'(m_state == 0));
    if (m_val[m_pc]) check("instr", 32'(instr), 32'(m_mem[m_pc]));
  endtask
  task automatic model_reset();
    m_state = 0; m_pc = 0; m_la = 0; m_fault = 0;
    m_stk.delete();
  endtask
  task automatic model_step();
    int nxt;
    if (m_state == 0) begin
      if (load_valid) begin
        m_mem[m_la] = load_instr; m_val[m_la] = 1; m_la = (m_la + 1) % 256;
      end
      if (start) begin m_state = 1; m_pc = 0; m_la = 0; end
    end else if (m_state == 2) begin
      m_state = start ? 1 : step ? 3 : 2;
    end else if (m_state == 4) begin
      if (clear) model_reset();
    end else if ((pcw && jm == 3) || (call && rtrn)) begin
      m_fault = 3; m_state = 4;
    end else if (call && m_stk.size() == DEPTH) begin
      m_fault = 1; m_state = 4;
    end else if (rtrn && m_stk.size() == 0) begin
      m_fault = 2; m_state = 4;
    end else begin
      nxt = m_pc;
      if (pcw)
        case (jm)
          2'd0: nxt = (m_pc + 1) % 256;
          2'd1: nxt = flag ? int'(m_mem[m_pc] % 256) : (m_pc + 1) % 256;
          default: nxt = m_stk[$];
        endcase
      if (call) m_stk.push_back((m_pc + 1) % 256);
      if (rtrn) void'(m_stk.pop_back());
      m_pc = nxt;
      m_state = (m_state == 3 || halt_req) ? 2 : 1;
    end
  endtask
  task automatic idle_in();
    load_valid = 0; load_instr = 0; start = 0; halt_req = 0; step = 0; clear = 0;
    pcw = 0; jm = 0; flag = 0; call = 0; rtrn = 0;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1 check_all();
    idle_in();
  endtask
  task automatic load(input logic [15:0] w);
    load_valid = 1; load_instr = w; tick();
  endtask
  task automatic exe(input bit p, input int j, input bit f, input bit c, input bit r);
    pcw = p; jm = 2'(j); flag = f; call = c; rtrn = r; tick();
  endtask
  function automatic logic [15:0] prog(input int i);
    logic [7:0] lo;
    lo = 8'(i) ^ 8'h5A;
    return i == 1 ? 16'hB020 : (i == 32 || i == 64) ? 16'hB040 : {8'hB0, lo};
  endfunction
  initial begin
    idle_in();
    model_reset();
    #12 check_all();
    rst = 0;
    load(16'h1000); load(16'h1001); load(16'h1002);
    start = 1; tick();
    check("ready_after_start", 32'(load_ready), 0);
    exe(1, 0, 0, 0, 0); check("run_pc1", 32'(instr), 32'h1001);
    exe(1, 0, 0, 0, 0); check("run_pc2", 32'(instr), 32'h1002);
    exe(1, 3, 0, 0, 0); check("illegal", 32'(fault), 3);
    clear = 1; tick();
    for (int i = 0; i < 256; i++) load(prog(i));
    start = 1; tick();
    exe(1, 0, 0, 0, 0);
    exe(1, 1, 1, 0, 0); check("jump", 32'(pc), 32'h20);
    exe(1, 1, 1, 1, 0); check("call_pc", 32'(pc), 32'h40); check("call_sp", 32'(sp), 1);
    exe(1, 2, 0, 0, 1); check("ret_pc", 32'(pc), 32'h21); check("ret_sp", 32'(sp), 0);
    exe(1, 1, 0, 0, 0); check("nojump", 32'(pc), 32'h22);
    exe(1, 2, 0, 0, 1); check("underflow", 32'(fault), 2); check("unf_pc", 32'(pc), 32'h22);
    clear = 1; tick();
    start = 1; tick();
    exe(1, 0, 0, 0, 0); exe(1, 1, 1, 0, 0); exe(1, 1, 1, 0, 0);
    repeat (5) exe(1, 1, 1, 1, 0);
    check("ovf_pc", 32'(pc), 32'h40); check("ovf_sp", 32'(sp), 4);
    check("ovf_state", 32'(state), 4); check("ovf_fault", 32'(fault), 1);
    clear = 1; tick(); check("clr_sp", 32'(sp), 0); check("clr_state", 32'(state), 0);
    start = 1; tick();
    repeat (5) exe(1, 0, 0, 0, 0);
    halt_req = 1; exe(1, 0, 0, 0, 0); check("halt_pc", 32'(pc), 6);
    repeat (10) exe(1, 0, 0, 0, 0);
    check("halt_hold", 32'(pc), 6);
    step = 1; exe(1, 0, 0, 0, 0); check("step_en", 32'(exec_en), 1);
    exe(1, 0, 0, 0, 0); check("step_pc", 32'(pc), 7); check("step_halt", 32'(state), 2);
    start = 1; exe(1, 0, 0, 0, 0);
    exe(1, 0, 0, 0, 0); check("resume", 32'(pc), 8);
    for (int k = 0; k < 300 && m_pc != 255; k++) exe(1, 0, 0, 0, 0);
    exe(1, 0, 0, 0, 0); check("wrap", 32'(pc), 0);
    repeat (48) exe(1, 0, 0, 0, 0);
    exe(1, 0, 0, 1, 0); exe(1, 0, 0, 1, 0); exe(1, 0, 0, 0, 0);
    check("pre_rst_pc", 32'(pc), 32'h33); check("pre_rst_sp", 32'(sp), 2);
    #3 rst = 1;
    #1 model_reset();
    check_all();
    check("rst_mem0", 32'(instr), 32'(prog(0)));
    #2 rst = 0;
    for (int k = 0; k < 257; k++) load(16'hC000 + 16'(k));
    check("load_wrap", 32'(instr), 32'hC100);
    for (int k = 0; k < 3000; k++) begin
      load_valid = 1'($urandom_range(0, 1)); load_instr = 16'($urandom);
      start = $urandom_range(0, 7) == 0; halt_req = $urandom_range(0, 15) == 0;
      step = $urandom_range(0, 3) == 0; clear = $urandom_range(0, 7) == 0;
      pcw = $urandom_range(0, 3) != 0; flag = 1'($urandom_range(0, 1));
      jm = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      call = $urandom_range(0, 5) == 0; rtrn = jm == 2'd2;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frank_sequencer.md
Name: frank_sequencer

Overview:
Parametrised program-sequencing front-end for the next FRANK6000 core: PC, next-PC logic, call/return stack and instruction memory, with a run-control FSM and a program-load handshake.
- Adds load / run / halt / single-step / fault modes.
- Adds stack overflow and underflow detection.
- Sits between the program loader and the decode path (Control_Unit, Jump_Control, datapath); o_exec_en gates every downstream architectural write.

Parameters:
PC_W, 8, PC and instruction-memory address width; memory depth 2**PC_W
INSTR_W, 16, instruction word width; jump target = o_instr[PC_W-1:0]
STACK_DEPTH, 16, call-stack entries (>=2)
SP_W, $clog2(STACK_DEPTH+1), stack-pointer width (derived)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous, active-high reset
i_load_valid  in  1  load word present
i_load_instr  in  INSTR_W  word to load
o_load_ready  out  1  high only in IDLE
i_start  in  1  IDLE→RUN (PC:=0) or HALT→RUN (resume)
i_halt_req  in  1  RUN→HALT
i_step  in  1  HALT→STEP (execute one instruction)
i_clear  in  1  FAULT→IDLE
i_PCw  in  1  PC write request from control unit
i_j_mode  in  2  0=PC+1, 1=conditional jump, 2=return, 3=illegal
i_jump_flag  in  1  jump taken (qualified condition)
i_call  in  1  push return address
i_rtrn  in  1  pop return address
o_PC  out  PC_W  current PC
o_instr  out  INSTR_W  mem[o_PC], combinational read
o_exec_en  out  1  high in RUN and STEP
o_state  out  3  FSM state encoding
o_sp  out  SP_W  stack occupancy
o_fault  out  2  0=none, 1=overflow, 2=underflow, 3=illegal

Behaviour:
- Reset (async, any state): state=IDLE, PC=0, sp=0, load_addr=0, o_fault=0, o_exec_en=0, o_load_ready=1. Memory contents are not cleared.
- States: IDLE=0, RUN=1, HALT=2, STEP=3, FAULT=4.
- IDLE:
  - i_load_valid writes i_load_instr to mem[load_addr] on the edge; load_addr increments and wraps 2**PC_W-1 → 0.
  - i_start: → RUN, PC:=0, load_addr:=0. If i_start and i_load_valid arrive together, the load is written first.
- RUN, or the single STEP cycle, when i_PCw=1, next PC is:
  - j_mode 0: PC+1, modulo 2**PC_W (wraps 2**PC_W-1 → 0).
  - j_mode 1: o_instr[PC_W-1:0] if i_jump_flag, else PC+1.
  - j_mode 2: top of stack.
- With i_PCw=0 the PC holds. Latency is one edge from request to new o_PC; o_instr follows combinationally.
- i_call (exec_en only): pushes PC+1 in the same edge as the PC update. Stack full (sp==STACK_DEPTH): push and PC update are suppressed, → FAULT, o_fault=1.
- i_rtrn (exec_en only): pops. Stack empty: pop and PC update are suppressed, → FAULT, o_fault=2.
- Illegal: j_mode==3 with i_PCw, or i_call and i_rtrn together. PC/stack are unchanged, → FAULT, o_fault=3.
- RUN:
  - i_halt_req → HALT. The instruction in that same cycle still executes (exec_en=1).
  - i_start in RUN is ignored.
- HALT:
  - exec_en=0; PC and stack are frozen.
  - i_start → RUN.
  - i_step → STEP. If both are high, i_start wins.
- STEP: lasts exactly one cycle with exec_en=1, then → HALT, unless the step faults, in which case → FAULT.
- FAULT:
  - exec_en=0; PC, sp and o_fault hold.
  - i_clear → IDLE: clears o_fault, sp=0, PC=0, load_addr=0.
  - All other controls are ignored.
- Loads outside IDLE: o_load_ready=0 and i_load_valid is ignored.
- Reset mid-operation: all state returns to reset values on i_rst assertion without waiting for a clock edge; the memory keeps its program.

Decomposition:
- Package frank_seq_pkg holds:
  - state encodings;
  - j_mode constants J_INC=0, J_JUMP=1, J_RTRN=2;
  - fault codes F_NONE, F_OVF, F_UNF, F_ILL.
- Sub-module frank_call_stack (params DEPTH, WIDTH):
  - ports: push, pop, din → top, sp, full, empty;
  - simultaneous push/pop is not exercised by the sequencer.
- FSM, PC register, next-PC mux, loader and memory stay in frank_sequencer.

Test Plan:
- Load + run: load 0x1000,0x1001,0x1002 in IDLE, i_start, i_PCw=1, j_mode=0 → o_PC 0,1,2 on successive edges; o_instr 0x1000,0x1001,0x1002; o_load_ready=0 after start.
- Jump, call, return:
  - jump: at PC=1 with o_instr[7:0]=0x20, j_mode=1, jump_flag=1 → PC=0x20.
  - call: at PC=0x20, i_call, j_mode=1, jump_flag=1, target 0x40 → PC=0x40, sp=1.
  - return: i_rtrn, j_mode=2 → PC=0x21, sp=0.
  - jump_flag=0 → PC+1.
- Stack faults:
  - overflow (STACK_DEPTH=4): 5 nested calls → 5th leaves PC unchanged, sp=4, o_state=FAULT, o_fault=1; i_clear → IDLE, sp=0.
  - underflow: return from empty stack → o_fault=2.
  - illegal: j_mode=3 with i_PCw → o_fault=3.
- Halt/step: in RUN at PC=5, i_halt_req → PC=6, then holds for 10 cycles. i_step → PC=7, exec_en high exactly one cycle, back in HALT. i_start → resumes incrementing.
- Wrap: PC=0xFF, j_mode=0 → PC=0x00. Load 257 words → the 257th overwrites address 0.
- Async reset mid-run: assert i_rst between edges at PC=0x33, sp=2 → immediately PC=0, sp=0, state=IDLE, o_load_ready=1; memory word at 0 unchanged.
